// File: rtl/mux_sel_pipe.sv
// N-way WIDTH-bit selector with one registered output stage and valid/ready handshake.
// Channels are picked either directly by index or by a round-robin scan of request bits.
module mux_sel_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 4,
    parameter int unsigned SELW  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rr_mode,
    input  logic               in_valid,
    input  logic [SELW-1:0]    selector,
    input  logic [N-1:0]       req,
    input  logic [N*WIDTH-1:0] data_in,
    output logic               in_ready,
    output logic [N-1:0]       gnt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_sel,
    output logic               sel_err
);

    localparam logic [SELW:0]   NumCh  = (SELW + 1)'(N);
    localparam logic [SELW-1:0] LastCh = SELW'(N - 1);
    localparam logic [N-1:0]    OneHot = N'(1);

    logic               r_valid;
    logic [WIDTH-1:0]   r_data;
    logic [SELW-1:0]    r_sel;
    logic               r_err;
    logic [SELW-1:0]    r_rr_ptr;

    logic [SELW:0]      w_scan;
    logic               w_rr_found;
    logic [SELW-1:0]    w_rr_idx;
    logic               w_sel_ok;
    logic               w_in_range;
    logic               w_want;
    logic               w_fire;
    logic [SELW-1:0]    w_chosen;
    logic [WIDTH-1:0]   w_sel_data;

    assign in_ready = !r_valid || out_ready;

    // Cyclic scan starting at r_rr_ptr; first requesting channel wins.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        w_scan     = '0;
        for (int i = 0; i < int'(N); i++) begin
            w_scan = {1'b0, r_rr_ptr} + (SELW + 1)'(i);
            if (w_scan >= NumCh) begin
                w_scan = w_scan - NumCh;
            end
            if (!w_rr_found && req[w_scan[SELW-1:0]]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = w_scan[SELW-1:0];
            end
        end
    end

    assign w_sel_ok   = ({1'b0, selector} < NumCh);
    assign w_chosen   = rr_mode ? w_rr_idx : selector;
    assign w_in_range = rr_mode || w_sel_ok;
    assign w_want     = rr_mode ? w_rr_found : in_valid;
    assign w_fire     = reset && w_want && in_ready;

    // Out-of-range indices match no channel and leave the word at zero.
    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (w_chosen == SELW'(k)) begin
                w_sel_data = data_in[k*WIDTH +: WIDTH];
            end
        end
    end

    assign gnt = (w_fire && w_in_range) ? (OneHot << w_chosen) : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_sel    <= '0;
            r_err    <= 1'b0;
            r_rr_ptr <= '0;
        end else begin
            if (w_fire) begin
                r_valid <= 1'b1;
                r_data  <= w_sel_data;
                r_sel   <= w_chosen;
                r_err   <= !w_in_range;
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
            if (w_fire && rr_mode) begin
                r_rr_ptr <= (w_chosen == LastCh) ? '0 : w_chosen + 1'b1;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_sel   = r_sel;
    assign sel_err   = r_err;

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Bench for mux_sel_pipe: a 3-channel and a 4-channel instance share stimulus and are
// compared every cycle against an abstract model, plus hand-computed directed checks.
module tb_mux_sel_pipe;

    logic         clk;
    logic         reset;
    logic         rr_mode;
    logic         in_valid;
    logic [1:0]   selector;
    logic [3:0]   req;
    logic [127:0] data_all;
    logic         out_ready;

    logic         a_in_ready, a_out_valid, a_sel_err;
    logic [2:0]   a_gnt;
    logic [31:0]  a_out_data;
    logic [1:0]   a_out_sel;
    logic         b_in_ready, b_out_valid, b_sel_err;
    logic [3:0]   b_gnt;
    logic [31:0]  b_out_data;
    logic [1:0]   b_out_sel;

    int n_checks = 0;
    int n_errors = 0;

    mux_sel_pipe #(.WIDTH(32), .N(3), .SELW(2)) u_dut_a (
        .clk       (clk),
        .reset     (reset),
        .rr_mode   (rr_mode),
        .in_valid  (in_valid),
        .selector  (selector),
        .req       (req[2:0]),
        .data_in   (data_all[95:0]),
        .in_ready  (a_in_ready),
        .gnt       (a_gnt),
        .out_valid (a_out_valid),
        .out_ready (out_ready),
        .out_data  (a_out_data),
        .out_sel   (a_out_sel),
        .sel_err   (a_sel_err)
    );

    mux_sel_pipe #(.WIDTH(32), .N(4), .SELW(2)) u_dut_b (
        .clk       (clk),
        .reset     (reset),
        .rr_mode   (rr_mode),
        .in_valid  (in_valid),
        .selector  (selector),
        .req       (req),
        .data_in   (data_all),
        .in_ready  (b_in_ready),
        .gnt       (b_gnt),
        .out_valid (b_out_valid),
        .out_ready (out_ready),
        .out_data  (b_out_data),
        .out_sel   (b_out_sel),
        .sel_err   (b_sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state per instance (0: N=3, 1: N=4).
    int          m_n[2] = '{3, 4};
    bit          m_v[2];
    logic [31:0] m_d[2];
    int          m_sel[2];
    bit          m_err[2];
    int          m_ptr[2];
    bit          m_live = 1'b0;

    function automatic int rr_pick(input int n, input int ptr, input logic [3:0] r);
        for (int k = 0; k < n; k++) begin
            if (r[(ptr + k) % n]) return (ptr + k) % n;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_gnt(input int i);
        int c;
        if (m_v[i] && !out_ready) return 4'b0;
        if (rr_mode) begin
            c = rr_pick(m_n[i], m_ptr[i], req);
            return (c < 0) ? 4'b0 : 4'(1 << c);
        end
        if (!in_valid || int'(selector) >= m_n[i]) return 4'b0;
        return 4'(1 << selector);
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int  c;
            bit  fire;
            if (!reset) begin
                m_v[i] = 0; m_d[i] = '0; m_sel[i] = 0; m_err[i] = 0; m_ptr[i] = 0;
            end else begin
                fire = 0;
                c    = -1;
                if (!m_v[i] || out_ready) begin
                    if (rr_mode) begin
                        c    = rr_pick(m_n[i], m_ptr[i], req);
                        fire = (c >= 0);
                    end else begin
                        c    = int'(selector);
                        fire = in_valid;
                    end
                end
                if (fire) begin
                    m_v[i]   = 1;
                    m_sel[i] = c;
                    if (c < m_n[i]) begin
                        m_d[i]   = data_all[c*32 +: 32];
                        m_err[i] = 0;
                    end else begin
                        m_d[i]   = '0;
                        m_err[i] = 1;
                    end
                    if (rr_mode) m_ptr[i] = (c + 1) % m_n[i];
                end else if (out_ready) begin
                    m_v[i] = 0;
                end
            end
        end
        if (!reset) m_live = 1'b1;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp(input int i, input logic ir, input logic [3:0] g, input logic ov,
                       input logic [31:0] od, input logic [1:0] os, input logic se);
        check($sformatf("model in_ready[%0d]", i), 64'(ir), 64'(!m_v[i] || out_ready));
        if (reset) check($sformatf("model gnt[%0d]", i), 64'(g), 64'(exp_gnt(i)));
        check($sformatf("model out_valid[%0d]", i), 64'(ov), 64'(m_v[i]));
        check($sformatf("model out_data[%0d]", i), 64'(od), 64'(m_d[i]));
        check($sformatf("model out_sel[%0d]", i), 64'(os), 64'(m_sel[i]));
        check($sformatf("model sel_err[%0d]", i), 64'(se), 64'(m_err[i]));
    endtask

    always @(negedge clk) begin
        if (m_live) begin
            cmp(0, a_in_ready, {1'b0, a_gnt}, a_out_valid, a_out_data, a_out_sel, a_sel_err);
            cmp(1, b_in_ready, b_gnt, b_out_valid, b_out_data, b_out_sel, b_sel_err);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; rr_mode = 1'b0; in_valid = 1'b1; selector = '0;
        req = '0; data_all = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1; in_valid = 1'b0;
        mid();
        check("t1 out_valid", 64'(a_out_valid), 64'd0);
        check("t1 out_data", 64'(a_out_data), 64'd0);
        check("t1 sel_err", 64'(a_sel_err), 64'd0);
        check("t1 in_ready", 64'(a_in_ready), 64'd1);

        step(); in_valid = 1'b1; selector = 2'd2; data_all[64 +: 32] = 32'hCAFEBABE; out_ready = 1'b1;
        mid();  check("t2 gnt", 64'(a_gnt), 64'b100);
        step(); in_valid = 1'b0;
        mid();  check("t2 out_valid", 64'(a_out_valid), 64'd1);
        check("t2 out_data", 64'(a_out_data), 64'hCAFEBABE);
        check("t2 out_sel", 64'(a_out_sel), 64'd2);

        step(); in_valid = 1'b1; selector = 2'd3;
        mid();  check("t3 gnt", 64'(a_gnt), 64'd0);
        step(); in_valid = 1'b0;
        mid();  check("t3 out_data", 64'(a_out_data), 64'd0);
        check("t3 sel_err", 64'(a_sel_err), 64'd1);
        check("t3 out_valid", 64'(a_out_valid), 64'd1);

        step(); out_ready = 1'b0; in_valid = 1'b1; selector = 2'd0; data_all[31:0] = 32'd1;
        mid();  check("t4 gnt A", 64'(a_gnt), 64'b001);
        step(); selector = 2'd1; data_all[63:32] = 32'd2;
        mid();  check("t4 stall in_ready", 64'(a_in_ready), 64'd0);
        check("t4 stall gnt", 64'(a_gnt), 64'd0);
        check("t4 stall data", 64'(a_out_data), 64'd1);
        step();
        mid();  check("t4 stall data 2", 64'(a_out_data), 64'd1);
        step(); out_ready = 1'b1;
        mid();  check("t4 release in_ready", 64'(a_in_ready), 64'd1);
        check("t4 gnt B", 64'(a_gnt), 64'b010);
        step(); in_valid = 1'b0;
        mid();  check("t4 out_data B", 64'(a_out_data), 64'd2);
        check("t4 out_sel B", 64'(a_out_sel), 64'd1);

        step(); rr_mode = 1'b1; req = 4'b1011;
        mid();  check("t5 gnt 1", 64'(b_gnt), 64'b0001);
        step();
        mid();  check("t5 gnt 2", 64'(b_gnt), 64'b0010);
        check("t5 sel 1", 64'(b_out_sel), 64'd0);
        step();
        mid();  check("t5 gnt 3", 64'(b_gnt), 64'b1000);
        check("t5 sel 2", 64'(b_out_sel), 64'd1);
        step();
        mid();  check("t5 gnt 4", 64'(b_gnt), 64'b0001);
        check("t5 sel 3", 64'(b_out_sel), 64'd3);
        step(); req = 4'b0000; out_ready = 1'b0;
        mid();  check("t5 sel 4", 64'(b_out_sel), 64'd0);
        check("t5 held", 64'(b_out_valid), 64'd1);

        step(); reset = 1'b0;
        step(); reset = 1'b1; req = 4'b1011; out_ready = 1'b1;
        mid();  check("t6 word lost", 64'(b_out_valid), 64'd0);
        check("t6 gnt restart", 64'(b_gnt), 64'b0001);
        step(); req = 4'b0000;
        mid();  check("t6 out_sel", 64'(b_out_sel), 64'd0);

        for (int n = 0; n < 3000; n++) begin
            step();
            reset     = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 15) == 0) rr_mode = ~rr_mode;
            in_valid  = ($urandom_range(0, 3) != 0);
            selector  = 2'($urandom_range(0, 3));
            req       = ($urandom_range(0, 4) == 0) ? 4'b0 : 4'($urandom_range(0, 15));
            data_all  = {$urandom, $urandom, $urandom, $urandom};
            out_ready = ($urandom_range(0, 9) < 7);
        end
        step();
        mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
